// File: rtl/bp_fe_cmd_acceptor.sv
// ---------------------------------------------------------------------------
// bp_fe_cmd_acceptor
//
// Front-end command acceptor. Takes packed commands from the back-end command
// queue, turns each accepted command into single-cycle action pulses
// (PC redirect, branch predictor update, ITLB/I$ maintenance) and tracks the
// front-end privilege level and translation mode.
//
// Handshake: fe_cmd_v_i marks fe_cmd_i as valid. fe_cmd_yumi_o is a
// same-cycle consume: when it is high the command on fe_cmd_i is taken on the
// coming rising edge, and every action pulse for that command is driven
// combinationally in that same cycle. yumi never rises without fe_cmd_v_i.
//
// Ports
//   clk_i, reset_i              clock, synchronous active-high reset
//   fe_cmd_i / fe_cmd_v_i       command and its valid
//   fe_cmd_yumi_o               command consumed this cycle
//   redirect_v_o/redirect_npc_o PC generator redirect pulse and target
//   mispredict_v_o, attaboy_v_o, attaboy_taken_o, br_metadata_o
//                               branch predictor update pulses and metadata
//   itlb_fill_v_o, itlb_fence_v_o, icache_fence_v_o
//                               maintenance action pulses
//   icache_fence_done_i         I$ fence complete
//   fetch_stall_o               fetch suppressed
//   priv_o, translation_en_o    registered privilege and translation mode
//   mispredict_cnt_o, attaboy_cnt_o
//                               saturating statistics counters
//   state_o                     FSM state (0 freeze, 1 run, 2 fence, 3 wait)
//
// Optional feature: define BP_FE_CMD_ACCEPTOR_STATS_EN to build the
// statistics counters; otherwise both counter outputs are tied to zero.
// ---------------------------------------------------------------------------
package bp_fe_cmd_acceptor_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_sv48_cfg    = 2'd1
    } bp_params_e;

    function automatic int vaddr_width_f(input bp_params_e cfg);
        return (cfg == e_bp_sv48_cfg) ? 48 : 39;
    endfunction

    function automatic int br_metadata_width_f(input bp_params_e cfg);
        return (cfg == e_bp_sv48_cfg) ? 45 : 36;
    endfunction

    typedef enum logic [3:0] {
        e_op_state_reset    = 4'd0,
        e_op_pc_redirection = 4'd1,
        e_op_icache_fill    = 4'd2,
        e_op_icache_fence   = 4'd3,
        e_op_attaboy        = 4'd4,
        e_op_itlb_fill      = 4'd5,
        e_op_itlb_fence     = 4'd6,
        e_op_wait           = 4'd7
    } bp_fe_command_queue_opcodes_e;

    typedef enum logic [2:0] {
        e_subop_resume             = 3'd0,
        e_subop_translation_switch = 3'd1,
        e_subop_eret               = 3'd2,
        e_subop_branch_mispredict  = 3'd3,
        e_subop_trap               = 3'd4,
        e_subop_interrupt          = 3'd5,
        e_subop_context_switch     = 3'd6
    } bp_fe_command_queue_subopcodes_e;

endpackage

module bp_fe_cmd_acceptor
    import bp_fe_cmd_acceptor_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    localparam int vaddr_width_p = vaddr_width_f(bp_params_p),
    localparam int branch_metadata_fwd_width_p = br_metadata_width_f(bp_params_p),
    // opcode + npc + subop + priv + translation_en + taken + metadata
    localparam int fe_cmd_width_lp = 4 + vaddr_width_p + 3 + 2 + 1 + 1 + branch_metadata_fwd_width_p
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [fe_cmd_width_lp-1:0]             fe_cmd_i,
    input  logic                                   fe_cmd_v_i,
    output logic                                   fe_cmd_yumi_o,
    output logic                                   redirect_v_o,
    output logic [vaddr_width_p-1:0]               redirect_npc_o,
    output logic                                   mispredict_v_o,
    output logic                                   attaboy_v_o,
    output logic                                   attaboy_taken_o,
    output logic [branch_metadata_fwd_width_p-1:0] br_metadata_o,
    output logic                                   itlb_fill_v_o,
    output logic                                   itlb_fence_v_o,
    output logic                                   icache_fence_v_o,
    input  logic                                   icache_fence_done_i,
    output logic                                   fetch_stall_o,
    output logic [1:0]                             priv_o,
    output logic                                   translation_en_o,
    output logic [15:0]                            mispredict_cnt_o,
    output logic [15:0]                            attaboy_cnt_o,
    output logic [1:0]                             state_o
);

    localparam logic [1:0] e_freeze = 2'd0;
    localparam logic [1:0] e_run    = 2'd1;
    localparam logic [1:0] e_fence  = 2'd2;
    localparam logic [1:0] e_wait   = 2'd3;

    localparam logic [1:0] priv_machine = 2'b11;

    typedef struct packed {
        logic [3:0]                             opcode;
        logic [vaddr_width_p-1:0]               npc;
        logic [2:0]                             subop;
        logic [1:0]                             priv;
        logic                                   translation_en;
        logic                                   branch_taken;
        logic [branch_metadata_fwd_width_p-1:0] branch_metadata;
    } bp_fe_cmd_s;

    bp_fe_cmd_s cmd;
    assign cmd = fe_cmd_i;

    logic [1:0] state_q, state_d;
    logic [1:0] priv_q, priv_d;
    logic       translation_en_q, translation_en_d;
    logic       yumi;

    // Commands are held off only while an I$ fence is outstanding.
    assign yumi          = ~reset_i & fe_cmd_v_i & (state_q != e_fence);
    assign fe_cmd_yumi_o = yumi;

    always_comb begin
        state_d          = state_q;
        priv_d           = priv_q;
        translation_en_d = translation_en_q;
        redirect_v_o     = 1'b0;
        redirect_npc_o   = '0;
        mispredict_v_o   = 1'b0;
        attaboy_v_o      = 1'b0;
        attaboy_taken_o  = 1'b0;
        br_metadata_o    = '0;
        itlb_fill_v_o    = 1'b0;
        itlb_fence_v_o   = 1'b0;
        icache_fence_v_o = 1'b0;

        if (yumi) begin
            if (state_q == e_freeze) begin
                // Frozen: only a state reset wakes the front end up.
                if (cmd.opcode == e_op_state_reset) begin
                    redirect_v_o     = 1'b1;
                    priv_d           = cmd.priv;
                    translation_en_d = cmd.translation_en;
                    state_d          = e_run;
                end
            end else if (!(state_q == e_wait && cmd.opcode == e_op_attaboy)) begin
                // Run, or wait with a non-attaboy command (wait drains
                // attaboys silently since fetch is not producing branches).
                case (cmd.opcode)
                    e_op_state_reset: begin
                        redirect_v_o     = 1'b1;
                        priv_d           = cmd.priv;
                        translation_en_d = cmd.translation_en;
                        state_d          = e_run;
                    end
                    e_op_pc_redirection: begin
                        redirect_v_o = 1'b1;
                        state_d      = e_run;
                        case (cmd.subop)
                            e_subop_branch_mispredict: begin
                                mispredict_v_o = 1'b1;
                                br_metadata_o  = cmd.branch_metadata;
                            end
                            e_subop_resume, e_subop_eret, e_subop_trap, e_subop_interrupt: begin
                                priv_d           = cmd.priv;
                                translation_en_d = cmd.translation_en;
                            end
                            e_subop_translation_switch: begin
                                translation_en_d = cmd.translation_en;
                            end
                            default: ;
                        endcase
                    end
                    e_op_icache_fill: begin
                        redirect_v_o = 1'b1;
                        state_d      = e_run;
                    end
                    e_op_icache_fence: begin
                        redirect_v_o     = 1'b1;
                        icache_fence_v_o = 1'b1;
                        state_d          = e_fence;
                    end
                    e_op_attaboy: begin
                        attaboy_v_o     = 1'b1;
                        attaboy_taken_o = cmd.branch_taken;
                        br_metadata_o   = cmd.branch_metadata;
                        state_d         = e_run;
                    end
                    e_op_itlb_fill: begin
                        redirect_v_o  = 1'b1;
                        itlb_fill_v_o = 1'b1;
                        state_d       = e_run;
                    end
                    e_op_itlb_fence: begin
                        redirect_v_o   = 1'b1;
                        itlb_fence_v_o = 1'b1;
                        state_d        = e_run;
                    end
                    e_op_wait: begin
                        redirect_v_o = 1'b1;
                        state_d      = e_wait;
                    end
                    default: ;
                endcase
            end
        end else if (state_q == e_fence && icache_fence_done_i) begin
            state_d = e_run;
        end

        if (redirect_v_o) begin
            redirect_npc_o = cmd.npc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= e_freeze;
            priv_q           <= priv_machine;
            translation_en_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            priv_q           <= priv_d;
            translation_en_q <= translation_en_d;
        end
    end

    assign priv_o           = priv_q;
    assign translation_en_o = translation_en_q;
    assign state_o          = state_q;

    // Attaboys do not disturb fetch; any other pending command will.
    assign fetch_stall_o = reset_i | (state_q != e_run)
                         | (fe_cmd_v_i & (cmd.opcode != e_op_attaboy));

`ifdef BP_FE_CMD_ACCEPTOR_STATS_EN
    logic [15:0] mispredict_cnt_q, mispredict_cnt_d;
    logic [15:0] attaboy_cnt_q, attaboy_cnt_d;

    always_comb begin
        mispredict_cnt_d = mispredict_cnt_q;
        attaboy_cnt_d    = attaboy_cnt_q;
        if (mispredict_v_o && (mispredict_cnt_q != 16'hFFFF)) begin
            mispredict_cnt_d = mispredict_cnt_q + 16'd1;
        end
        if (attaboy_v_o && (attaboy_cnt_q != 16'hFFFF)) begin
            attaboy_cnt_d = attaboy_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mispredict_cnt_q <= 16'd0;
            attaboy_cnt_q    <= 16'd0;
        end else begin
            mispredict_cnt_q <= mispredict_cnt_d;
            attaboy_cnt_q    <= attaboy_cnt_d;
        end
    end

    assign mispredict_cnt_o = mispredict_cnt_q;
    assign attaboy_cnt_o    = attaboy_cnt_q;
`else
    assign mispredict_cnt_o = 16'd0;
    assign attaboy_cnt_o    = 16'd0;
`endif

endmodule

// File: tb/tb_bp_fe_cmd_acceptor.sv
// ---------------------------------------------------------------------------
// Testbench for bp_fe_cmd_acceptor. Directed scenarios followed by random
// commands, all checked cycle by cycle against a behavioural model of the
// command rules, plus a redirect-target scoreboard and a counter saturation
// run. Works with or without BP_FE_CMD_ACCEPTOR_STATS_EN.
// ---------------------------------------------------------------------------
module tb_bp_fe_cmd_acceptor;
    import bp_fe_cmd_acceptor_pkg::*;

    localparam int VW = vaddr_width_f(e_bp_default_cfg);
    localparam int MW = br_metadata_width_f(e_bp_default_cfg);
    localparam int CW = 4 + VW + 3 + 2 + 1 + 1 + MW;

`ifdef BP_FE_CMD_ACCEPTOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // state_o encoding
    localparam int S_FREEZE = 0;
    localparam int S_RUN    = 1;
    localparam int S_FENCE  = 2;
    localparam int S_WAIT   = 3;

    localparam logic [3:0] OP_SR      = e_op_state_reset;
    localparam logic [3:0] OP_PCR     = e_op_pc_redirection;
    localparam logic [3:0] OP_ICFILL  = e_op_icache_fill;
    localparam logic [3:0] OP_ICFENCE = e_op_icache_fence;
    localparam logic [3:0] OP_ATT     = e_op_attaboy;
    localparam logic [3:0] OP_ITFILL  = e_op_itlb_fill;
    localparam logic [3:0] OP_ITFENCE = e_op_itlb_fence;
    localparam logic [3:0] OP_WAIT    = e_op_wait;

    localparam logic [2:0] SUB_RES  = e_subop_resume;
    localparam logic [2:0] SUB_TSW  = e_subop_translation_switch;
    localparam logic [2:0] SUB_ERET = e_subop_eret;
    localparam logic [2:0] SUB_MIS  = e_subop_branch_mispredict;
    localparam logic [2:0] SUB_TRAP = e_subop_trap;
    localparam logic [2:0] SUB_INT  = e_subop_interrupt;

    typedef struct packed {
        logic [3:0]    opcode;
        logic [VW-1:0] npc;
        logic [2:0]    subop;
        logic [1:0]    priv;
        logic          tren;
        logic          taken;
        logic [MW-1:0] md;
    } cmd_t;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [CW-1:0] fe_cmd_i = '0;
    logic          fe_cmd_v_i = 1'b0;
    logic          icache_fence_done_i = 1'b0;
    logic          fe_cmd_yumi_o, redirect_v_o, mispredict_v_o, attaboy_v_o, attaboy_taken_o;
    logic [VW-1:0] redirect_npc_o;
    logic [MW-1:0] br_metadata_o;
    logic          itlb_fill_v_o, itlb_fence_v_o, icache_fence_v_o, fetch_stall_o;
    logic [1:0]    priv_o;
    logic          translation_en_o;
    logic [15:0]   mispredict_cnt_o, attaboy_cnt_o;
    logic [1:0]    state_o;

    always #5 clk = ~clk;

    bp_fe_cmd_acceptor #(.bp_params_p(e_bp_default_cfg)) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .fe_cmd_i           (fe_cmd_i),
        .fe_cmd_v_i         (fe_cmd_v_i),
        .fe_cmd_yumi_o      (fe_cmd_yumi_o),
        .redirect_v_o       (redirect_v_o),
        .redirect_npc_o     (redirect_npc_o),
        .mispredict_v_o     (mispredict_v_o),
        .attaboy_v_o        (attaboy_v_o),
        .attaboy_taken_o    (attaboy_taken_o),
        .br_metadata_o      (br_metadata_o),
        .itlb_fill_v_o      (itlb_fill_v_o),
        .itlb_fence_v_o     (itlb_fence_v_o),
        .icache_fence_v_o   (icache_fence_v_o),
        .icache_fence_done_i(icache_fence_done_i),
        .fetch_stall_o      (fetch_stall_o),
        .priv_o             (priv_o),
        .translation_en_o   (translation_en_o),
        .mispredict_cnt_o   (mispredict_cnt_o),
        .attaboy_cnt_o      (attaboy_cnt_o),
        .state_o            (state_o)
    );

    // ---------------- scoreboard / model state ----------------
    int            n_total = 0;
    int            n_bad   = 0;
    int            n_redir = 0;
    logic [VW-1:0] exp_q[$];

    int         m_state = S_FREEZE;
    logic [1:0] m_priv  = 2'b11;
    logic       m_tren  = 1'b0;
    int         m_mis   = 0;
    int         m_att   = 0;
    bit         m_known = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [3:0] op, input logic [63:0] npc, input logic [2:0] sub,
                                input logic [1:0] pv, input logic te, input logic tk, input logic [63:0] md);
        cmd_t c;
        c.opcode = op;
        c.npc    = VW'(npc);
        c.subop  = sub;
        c.priv   = pv;
        c.tren   = te;
        c.taken  = tk;
        c.md     = MW'(md);
        return c;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic check_regs();
        check_eq("state", 64'(state_o), 64'(m_state));
        check_eq("priv", 64'(priv_o), 64'(m_priv));
        check_eq("translation_en", 64'(translation_en_o), 64'(m_tren));
        check_eq("mispredict_cnt", 64'(mispredict_cnt_o), 64'(m_mis));
        check_eq("attaboy_cnt", 64'(attaboy_cnt_o), 64'(m_att));
    endtask

    // ---------------- driver: one cycle with model + checks ----------------
    task automatic step(input bit rst, input bit v, input cmd_t c, input bit done);
        bit acc, live, e_red, e_mis, e_att, e_itf, e_itfn, e_icf, ld_p, ld_t, e_stall;
        int nxt;
        @(negedge clk);
        if (m_known) check_regs();
        reset_i             = rst;
        fe_cmd_v_i          = v;
        fe_cmd_i            = c;
        icache_fence_done_i = done;
        #1;

        acc  = !rst && v && (m_state != S_FENCE);
        live = acc && (m_state == S_RUN || (m_state == S_WAIT && c.opcode != OP_ATT));
        {e_red, e_mis, e_att, e_itf, e_itfn, e_icf, ld_p, ld_t} = '0;
        nxt = m_state;
        if (acc && m_state == S_FREEZE && c.opcode == OP_SR) begin
            e_red = 1'b1; ld_p = 1'b1; ld_t = 1'b1; nxt = S_RUN;
        end
        if (live) begin
            e_red  = c.opcode inside {OP_SR, OP_PCR, OP_ICFILL, OP_ICFENCE, OP_ITFILL, OP_ITFENCE, OP_WAIT};
            e_mis  = (c.opcode == OP_PCR) && (c.subop == SUB_MIS);
            e_att  = (c.opcode == OP_ATT);
            e_itf  = (c.opcode == OP_ITFILL);
            e_itfn = (c.opcode == OP_ITFENCE);
            e_icf  = (c.opcode == OP_ICFENCE);
            ld_p   = (c.opcode == OP_SR) ||
                     ((c.opcode == OP_PCR) && (c.subop inside {SUB_RES, SUB_ERET, SUB_TRAP, SUB_INT}));
            ld_t   = ld_p || ((c.opcode == OP_PCR) && (c.subop == SUB_TSW));
            if (c.opcode == OP_ICFENCE) nxt = S_FENCE;
            else if (c.opcode == OP_WAIT) nxt = S_WAIT;
            else if (c.opcode inside {OP_SR, OP_PCR, OP_ICFILL, OP_ATT, OP_ITFILL, OP_ITFENCE}) nxt = S_RUN;
        end
        if (!rst && m_state == S_FENCE && done) nxt = S_RUN;
        e_stall = rst || (m_state != S_RUN) || (v && c.opcode != OP_ATT);

        check_eq("yumi", 64'(fe_cmd_yumi_o), 64'(acc));
        check_eq("redirect_v", 64'(redirect_v_o), 64'(e_red));
        check_eq("redirect_npc", 64'(redirect_npc_o), e_red ? 64'(c.npc) : 64'd0);
        check_eq("mispredict_v", 64'(mispredict_v_o), 64'(e_mis));
        check_eq("attaboy_v", 64'(attaboy_v_o), 64'(e_att));
        check_eq("attaboy_taken", 64'(attaboy_taken_o), e_att ? 64'(c.taken) : 64'd0);
        check_eq("br_metadata", 64'(br_metadata_o), (e_att || e_mis) ? 64'(c.md) : 64'd0);
        check_eq("itlb_fill_v", 64'(itlb_fill_v_o), 64'(e_itf));
        check_eq("itlb_fence_v", 64'(itlb_fence_v_o), 64'(e_itfn));
        check_eq("icache_fence_v", 64'(icache_fence_v_o), 64'(e_icf));
        check_eq("fetch_stall", 64'(fetch_stall_o), 64'(e_stall));

        if (e_red) exp_q.push_back(c.npc);
        if (redirect_v_o === 1'b1) begin
            n_redir++;
            if (exp_q.size() != 0) check_eq("redir_sb_npc", 64'(redirect_npc_o), 64'(exp_q.pop_front()));
            else check_eq("redir_sb_extra", 64'(redirect_v_o), 64'd0);
        end

        if (rst) begin
            m_state = S_FREEZE; m_priv = 2'b11; m_tren = 1'b0; m_mis = 0; m_att = 0;
            m_known = 1'b1;
        end else begin
            if (ld_p) m_priv = c.priv;
            if (ld_t) m_tren = c.tren;
            if (STATS && e_mis) m_mis = sat16(m_mis + 1);
            if (STATS && e_att) m_att = sat16(m_att + 1);
            m_state = nxt;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, mk(OP_ATT, 64'd0, 3'd0, 2'd0, 1'b0, 1'b0, 64'd0), 1'b0);
    endtask

    // Hold an attaboy valid for n consecutive cycles without per-cycle checks.
    task automatic bulk_attaboys(input int n);
        cmd_t c;
        c = mk(OP_ATT, 64'd0, 3'd0, 2'd0, 1'b0, 1'b1, 64'h5a);
        @(negedge clk);
        check_regs();
        reset_i = 1'b0; fe_cmd_v_i = 1'b1; fe_cmd_i = c; icache_fence_done_i = 1'b0;
        repeat (n) @(negedge clk);
        fe_cmd_v_i = 1'b0;
        if (STATS) m_att = sat16(m_att + n);
        check_eq("sat_attaboy_cnt", 64'(attaboy_cnt_o), 64'(m_att));
        check_eq("sat_state", 64'(state_o), 64'(S_RUN));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        cmd_t c, pend;
        int   yumi_low, r0;

        // Reset with a command presented: nothing may be consumed.
        step(1'b1, 1'b1, mk(OP_PCR, 64'h80, SUB_RES, 2'd0, 1'b1, 1'b0, 64'd0), 1'b0);
        step(1'b1, 1'b1, mk(OP_SR, 64'h44, 3'd0, 2'd0, 1'b1, 1'b0, 64'd0), 1'b0);

        // Frozen: redirect is swallowed, then state_reset wakes up.
        step(1'b0, 1'b1, mk(OP_PCR, 64'h80, SUB_RES, 2'd0, 1'b1, 1'b0, 64'd0), 1'b0);
        check_eq("t1_frozen_no_redirect", 64'(redirect_v_o), 64'd0);
        step(1'b0, 1'b1, mk(OP_SR, 64'h8000_0000, 3'd0, 2'd1, 1'b0, 1'b0, 64'd0), 1'b0);
        check_eq("t1_sr_npc", 64'(redirect_npc_o), 64'h8000_0000);
        idle();
        check_eq("t1_priv", 64'(priv_o), 64'd1);
        check_eq("t1_state", 64'(state_o), 64'(S_RUN));

        // I$ fence with a pending command held off until done.
        step(1'b0, 1'b1, mk(OP_ICFENCE, 64'h200, 3'd0, 2'd0, 1'b0, 1'b0, 64'd0), 1'b0);
        pend = mk(OP_ITFILL, 64'h300, 3'd0, 2'd0, 1'b0, 1'b0, 64'd0);
        yumi_low = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, pend, 1'b0);
            if (fe_cmd_yumi_o === 1'b0) yumi_low++;
        end
        step(1'b0, 1'b1, pend, 1'b1);
        if (fe_cmd_yumi_o === 1'b0) yumi_low++;
        check_eq("t2_yumi_low_cycles", 64'(yumi_low), 64'd11);
        step(1'b0, 1'b1, pend, 1'b0);
        check_eq("t2_accept_after_done", 64'(fe_cmd_yumi_o), 64'd1);
        check_eq("t2_itlb_fill", 64'(itlb_fill_v_o), 64'd1);

        // Back-to-back attaboy / mispredict / attaboy.
        r0 = n_redir;
        step(1'b0, 1'b1, mk(OP_ATT, 64'h0, 3'd0, 2'd0, 1'b0, 1'b1, 64'h1234), 1'b0);
        step(1'b0, 1'b1, mk(OP_PCR, 64'h480, SUB_MIS, 2'd0, 1'b0, 1'b0, 64'h9_8765_4321), 1'b0);
        step(1'b0, 1'b1, mk(OP_ATT, 64'h0, 3'd0, 2'd0, 1'b0, 1'b0, 64'h77), 1'b0);
        idle();
        check_eq("t3_redirect_count", 64'(n_redir - r0), 64'd1);
        check_eq("t3_attaboy_cnt", 64'(attaboy_cnt_o), STATS ? 64'd2 : 64'd0);
        check_eq("t3_mispredict_cnt", 64'(mispredict_cnt_o), STATS ? 64'd1 : 64'd0);

        // Wait, ignored attaboy, interrupt redirect back to run.
        step(1'b0, 1'b1, mk(OP_WAIT, 64'h400, 3'd0, 2'd0, 1'b0, 1'b0, 64'd0), 1'b0);
        step(1'b0, 1'b1, mk(OP_ATT, 64'h0, 3'd0, 2'd0, 1'b0, 1'b1, 64'h55), 1'b0);
        check_eq("t4_wait_attaboy_silent", 64'(attaboy_v_o), 64'd0);
        step(1'b0, 1'b1, mk(OP_PCR, 64'h100, SUB_INT, 2'd3, 1'b1, 1'b0, 64'd0), 1'b0);
        check_eq("t4_int_npc", 64'(redirect_npc_o), 64'h100);
        idle();
        check_eq("t4_state_run", 64'(state_o), 64'(S_RUN));
        check_eq("t4_no_stall", 64'(fetch_stall_o), 64'd0);

        // Reset mid-fence: a later done must not leave freeze.
        step(1'b0, 1'b1, mk(OP_ICFENCE, 64'h600, 3'd0, 2'd0, 1'b0, 1'b0, 64'd0), 1'b0);
        step(1'b1, 1'b0, mk(OP_ATT, 64'd0, 3'd0, 2'd0, 1'b0, 1'b0, 64'd0), 1'b0);
        step(1'b0, 1'b0, mk(OP_ATT, 64'd0, 3'd0, 2'd0, 1'b0, 1'b0, 64'd0), 1'b1);
        idle();
        check_eq("t5_fence_abandoned", 64'(state_o), 64'(S_FREEZE));

        // Random commands.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 19);
            case (r)
                0, 1:         c.opcode = OP_SR;
                2, 3, 4, 5:   c.opcode = OP_PCR;
                6:            c.opcode = OP_ICFILL;
                7:            c.opcode = OP_ICFENCE;
                8, 9, 10, 11: c.opcode = OP_ATT;
                12:           c.opcode = OP_ITFILL;
                13:           c.opcode = OP_ITFENCE;
                14:           c.opcode = OP_WAIT;
                15:           c.opcode = 4'($urandom_range(8, 15));
                default:      c.opcode = OP_PCR;
            endcase
            c.npc   = VW'({$urandom(), $urandom()});
            c.subop = 3'($urandom_range(0, 7));
            c.priv  = 2'($urandom_range(0, 3));
            c.tren  = 1'($urandom_range(0, 1));
            c.taken = 1'($urandom_range(0, 1));
            c.md    = MW'({$urandom(), $urandom()});
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, c, $urandom_range(0, 5) == 0);
        end

        // Counter saturation.
        step(1'b1, 1'b0, mk(OP_ATT, 64'd0, 3'd0, 2'd0, 1'b0, 1'b0, 64'd0), 1'b0);
        step(1'b0, 1'b1, mk(OP_SR, 64'h1000, 3'd0, 2'd3, 1'b0, 1'b0, 64'd0), 1'b0);
        bulk_attaboys(1000);
        bulk_attaboys(64534);
        check_eq("sat_below_max", 64'(attaboy_cnt_o), STATS ? 64'hFFFE : 64'd0);
        bulk_attaboys(1);
        bulk_attaboys(4465);
        check_eq("sat_at_max", 64'(attaboy_cnt_o), STATS ? 64'hFFFF : 64'd0);

        @(negedge clk);
        check_regs();
        check_eq("redir_sb_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
